// File: rtl/egd_bitstream_feeder.sv
// egd_bitstream_feeder: Wishbone-slave word FIFO that serializes 32-bit Annex-B words into
// 16-bit halfwords (upper first) for the decoder. Define EGD_FEEDER_IRQ_EN to add irq_o and CTRL.IRQ_EN.
module egd_bitstream_feeder #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] bs_data_o,
    output logic [1:0]  bs_ctrl_o,
    input  logic        bs_ready_i
`ifdef EGD_FEEDER_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_e;

    // Bus request capture and response registers
    logic          ack_q, ack_d;
    logic [31:0]   dat_o_q, dat_o_d;
    logic          req_we_q, req_we_d;
    logic [1:0]    req_off_q, req_off_d;
    logic [31:0]   req_dat_q, req_dat_d;

    // Control / status registers
    logic          en_q, en_d;
    logic          eos_q, eos_d;
    logic          ovf_q, ovf_d;

    // FIFO
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level;
    logic          fifo_empty, fifo_full;

    // Serializer
    state_e        state_q, state_d;
    logic [31:0]   hold_q, hold_d;
    logic [15:0]   bs_data_q, bs_data_d;
    logic [1:0]    bs_ctrl_q, bs_ctrl_d;

    logic          req_hit, req_new;
    logic          wr_data, wr_ctrl, flush;
    logic          avail, pop, push_ok, ovf_set, hs, last_hs;
    logic [31:0]   pop_word;
    logic [31:0]   rd_word;
    logic          irq_en_rd;
    logic          unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign bs_data_o = bs_data_q;
    assign bs_ctrl_o = bs_ctrl_q;

    assign req_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req_new = wbs_stb_i & wbs_cyc_i & req_hit & ~ack_q;

    // Side effects commit on the ack cycle, from the request captured one cycle earlier
    assign wr_data = ack_q & req_we_q & (req_off_q == OFF_DATA);
    assign wr_ctrl = ack_q & req_we_q & (req_off_q == OFF_CTRL);
    assign flush   = wr_ctrl & req_dat_q[2];

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef EGD_FEEDER_IRQ_EN
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [PW-1:0] level_d;

    assign irq_en_rd = irq_en_q;
    assign irq_o     = irq_q;
    assign level_d   = wr_ptr_d - rd_ptr_d;

    // Pulse when the level drains through the half-full mark
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = req_dat_q[3];
        end
        irq_d = en_q & irq_en_q
              & (level   == PW'(FIFO_DEPTH / 2))
              & (level_d == PW'(FIFO_DEPTH / 2 - 1));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        unique case (wbs_adr_i[3:2])
            OFF_CTRL:   rd_word = {28'd0, irq_en_rd, 1'b0, eos_q, en_q};
            OFF_STATUS: rd_word = {20'd0, ovf_q, (state_q != ST_IDLE), fifo_full, fifo_empty, 8'(level)};
            default:    rd_word = '0;
        endcase
    end

    // Wishbone response: one-cycle registered ack, read data sampled in the request cycle
    always_comb begin
        ack_d     = req_new;
        dat_o_d   = '0;
        req_we_d  = req_we_q;
        req_off_d = req_off_q;
        req_dat_d = req_dat_q;
        if (req_new) begin
            req_we_d  = wbs_we_i;
            req_off_d = wbs_adr_i[3:2];
            req_dat_d = wbs_dat_i;
            if (!wbs_we_i) begin
                dat_o_d = rd_word;
            end
        end
    end

    // A word pushed this cycle into an empty FIFO can be popped straight through
    assign avail    = ~fifo_empty | wr_data;
    assign hs       = (state_q != ST_IDLE) & bs_ready_i;
    assign last_hs  = (state_q == ST_LO) & bs_ready_i & bs_ctrl_q[1];
    assign pop_word = fifo_empty ? req_dat_q : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_q && avail) begin
                    pop     = 1'b1;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (hs) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (hs) begin
                    if (en_q && avail) begin
                        pop     = 1'b1;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
        end
        if (pop) begin
            hold_d = pop_word;
        end
    end

    assign push_ok = wr_data & (~fifo_full | pop);
    assign ovf_set = wr_data & fifo_full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        en_d     = en_q;
        eos_d    = eos_q;
        ovf_d    = ovf_q | ovf_set;
        if (last_hs) begin
            eos_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d  = req_dat_q[0];
            eos_d = req_dat_q[1];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            eos_d    = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    // Outputs registered from next state so valid/last/data line up with the FSM
    always_comb begin
        bs_data_d    = bs_data_q;
        bs_ctrl_d    = 2'b00;
        bs_ctrl_d[0] = (state_d != ST_IDLE);
        bs_ctrl_d[1] = (state_d == ST_LO) & eos_d & (wr_ptr_d == rd_ptr_d);
        if (state_d == ST_HI) begin
            bs_data_d = hold_d[31:16];
        end else if (state_d == ST_LO) begin
            bs_data_d = hold_d[15:0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= req_dat_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
            req_we_q  <= 1'b0;
            req_off_q <= '0;
            req_dat_q <= '0;
            en_q      <= 1'b0;
            eos_q     <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            bs_data_q <= '0;
            bs_ctrl_q <= 2'b00;
        end else begin
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            req_we_q  <= req_we_d;
            req_off_q <= req_off_d;
            req_dat_q <= req_dat_d;
            en_q      <= en_d;
            eos_q     <= eos_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            bs_data_q <= bs_data_d;
            bs_ctrl_q <= bs_ctrl_d;
        end
    end

endmodule
